// File: rtl/answer_checker.sv
// answer_checker: guessing-game round controller. Draws a pseudo-random
// target from a free-running LFSR, takes a debounced button press as the
// submit event, compares the sampled guess and emits one-cycle result pulses.
module answer_checker #(
    parameter int          WIDTH           = 4,
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter int          MAX_TRIES       = 3,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             submit,
    input  logic [WIDTH-1:0] guess,
    output logic [WIDTH-1:0] target,
    output logic             round_active,
    output logic [3:0]       tries_left,
    output logic             is_equal,
    output logic             is_wrong,
    output logic             round_lost
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [3:0]      TRIES_INIT = 4'(MAX_TRIES);
    // Galois taps for x^16 + x^14 + x^13 + x^11 + 1 (right-shifting form)
    localparam logic [15:0]     LFSR_TAPS  = 16'hB400;

    typedef enum logic [1:0] {
        ST_NEW_ROUND = 2'd0,
        ST_ARMED     = 2'd1,
        ST_JUDGE     = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               sync1_q, sync1_d;
    logic               sync2_q, sync2_d;
    logic               stable_q, stable_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [15:0]        lfsr_q, lfsr_d;
    logic [WIDTH-1:0]   target_q, target_d;
    logic [WIDTH-1:0]   guess_q, guess_d;
    logic [3:0]         tries_left_q, tries_left_d;
    logic               round_active_q, round_active_d;
    logic               is_equal_q, is_equal_d;
    logic               is_wrong_q, is_wrong_d;
    logic               round_lost_q, round_lost_d;
    logic               press_evt;
    logic               guess_match;

    // Synchronize the raw button and debounce it; a press is the stable 0->1 edge.
    always_comb begin
        sync1_d  = submit;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_MAX) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
        press_evt = stable_d & ~stable_q;
    end

    // Free-running LFSR; advances every cycle regardless of the round state.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    end

    // Next-state logic for the round FSM.
    always_comb begin
        guess_match = (guess_q == target_q);
        state_d     = state_q;
        case (state_q)
            ST_NEW_ROUND: state_d = ST_ARMED;
            ST_ARMED:     if (press_evt) state_d = ST_JUDGE;
            ST_JUDGE: begin
                if (guess_match || (tries_left_q <= 4'd1)) begin
                    state_d = ST_NEW_ROUND;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            default:      state_d = ST_NEW_ROUND;
        endcase
    end

    // Output and datapath updates; every result is registered so pulses are glitch-free.
    always_comb begin
        target_d       = target_q;
        guess_d        = guess_q;
        tries_left_d   = tries_left_q;
        is_equal_d     = 1'b0;
        is_wrong_d     = 1'b0;
        round_lost_d   = 1'b0;
        round_active_d = (state_d == ST_ARMED);
        case (state_q)
            ST_NEW_ROUND: begin
                target_d     = lfsr_q[WIDTH-1:0];
                tries_left_d = TRIES_INIT;
            end
            ST_ARMED: begin
                if (press_evt) guess_d = guess;
            end
            ST_JUDGE: begin
                if (guess_match) begin
                    is_equal_d = 1'b1;
                end else begin
                    is_wrong_d = 1'b1;
                    if (tries_left_q != 4'd0) tries_left_d = tries_left_q - 4'd1;
                    round_lost_d = (tries_left_q <= 4'd1);
                end
            end
            default: ;
        endcase
    end

    // Control state with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_NEW_ROUND;
            sync1_q        <= 1'b0;
            sync2_q        <= 1'b0;
            stable_q       <= 1'b0;
            cnt_q          <= '0;
            lfsr_q         <= LFSR_SEED;
            target_q       <= '0;
            tries_left_q   <= TRIES_INIT;
            round_active_q <= 1'b0;
            is_equal_q     <= 1'b0;
            is_wrong_q     <= 1'b0;
            round_lost_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            sync1_q        <= sync1_d;
            sync2_q        <= sync2_d;
            stable_q       <= stable_d;
            cnt_q          <= cnt_d;
            lfsr_q         <= lfsr_d;
            target_q       <= target_d;
            tries_left_q   <= tries_left_d;
            round_active_q <= round_active_d;
            is_equal_q     <= is_equal_d;
            is_wrong_q     <= is_wrong_d;
            round_lost_q   <= round_lost_d;
        end
    end

    // Sampled guess is pure data and is always written before it is judged.
    always_ff @(posedge clk) begin
        guess_q <= guess_d;
    end

    assign target       = target_q;
    assign round_active = round_active_q;
    assign tries_left   = tries_left_q;
    assign is_equal     = is_equal_q;
    assign is_wrong     = is_wrong_q;
    assign round_lost   = round_lost_q;

endmodule

// File: doc/answer_checker.md
Name: answer_checker

Overview:
- Round controller that generates the `is_equal` strobe consumed by the score counter.
- Draws a pseudo-random target and accepts a player's binary guess on a debounced submit-button press.
- Compares the guess with the target and emits one-cycle correct or wrong pulses.
- Starts a new round on a correct answer or when the tries run out.

Parameters:
- `WIDTH`, 4: guess/target width in bits (1..16).
- `DEBOUNCE_CYCLES`, 500000: consecutive stable cycles required before the submit level is accepted (≥2).
- `MAX_TRIES`, 3: wrong guesses allowed per round before it is forfeited (1..15).
- `LFSR_SEED`, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- `clk`  in  1: system clock; all state updates on posedge.
- `rst`  in  1: synchronous, active-high reset.
- `submit`  in  1: raw, asynchronous, bouncy push-button level.
- `guess`  in  WIDTH: player switch value; sampled at the accepted press.
- `target`  out  WIDTH: current round target, for display.
- `round_active`  out  1: high while a guess is accepted.
- `tries_left`  out  4: remaining wrong guesses in the current round.
- `is_equal`  out  1: one-cycle pulse on a correct guess; connects to the score counter.
- `is_wrong`  out  1: one-cycle pulse on an incorrect guess.
- `round_lost`  out  1: one-cycle pulse, coincident with the final `is_wrong` of a forfeited round.

Behaviour:
- Reset has priority over everything. Registers after `rst`:
  - 2-flop synchronizer = 0.
  - Debounce stable level = 0, debounce counter = 0.
  - LFSR = `LFSR_SEED`.
  - `target` = 0, state = NEW_ROUND, `tries_left` = `MAX_TRIES`.
  - `round_active`, `is_equal`, `is_wrong`, `round_lost` = 0.
- Reset mid-round discards the round. Any pending pulse is cancelled.
- Input conditioning:
  - `submit` passes through a 2-flop synchronizer.
  - Debouncer: the counter increments each cycle the synced level differs from the stable level, and clears when they agree.
  - When the counter reaches `DEBOUNCE_CYCLES`, the stable level takes the synced level and the counter clears.
  - `press_evt` is a 1-cycle internal pulse on a stable 0→1 transition.
  - A button held high through reset produces a press `DEBOUNCE_CYCLES`+2 cycles after reset deasserts.
- LFSR:
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Advances every non-reset cycle, independent of state.
- State NEW_ROUND (1 cycle):
  - `target` ← LFSR[WIDTH-1:0].
  - `tries_left` ← `MAX_TRIES`.
  - `round_active` = 0. Next state is ARMED.
- State ARMED:
  - `round_active` = 1.
  - On `press_evt`: `guess_q` ← `guess`, then go to JUDGE.
  - No press: stay in ARMED.
- State JUDGE (1 cycle): `round_active` = 0.
  - If `guess_q` == `target`: register `is_equal`=1 for the next cycle, then go to NEW_ROUND.
  - Otherwise: register `is_wrong`=1 and `tries_left` ← `tries_left`−1.
    - If the new `tries_left` is 0: also `round_lost`=1, go to NEW_ROUND.
    - Else go to ARMED.
- Latency:
  - `press_evt` in cycle N (ARMED), JUDGE in N+1, result pulse high in N+2 only.
  - On a correct guess, the new `target` is visible at N+3; NEW_ROUND occupies N+2.
- Pulses:
  - `is_equal` and `is_wrong` are registered, never high together, and never longer than 1 cycle.
  - Successive pulses are at least `DEBOUNCE_CYCLES`+3 cycles apart, because every press requires release+press.
- `press_evt` arriving in NEW_ROUND or JUDGE is dropped, not queued.
- `guess` changes after the sampling edge do not affect the result.
- The target may repeat across rounds. An LFSR low-bits value of 0 is a legal target.
- `tries_left` never underflows. It is reloaded only in NEW_ROUND.

Test Plan (`DEBOUNCE_CYCLES`=4, `WIDTH`=4, `MAX_TRIES`=3):
1. Reset then idle: all pulses 0, `tries_left`=3, `round_active`=1 two cycles after `rst` deasserts, and `target` = LFSR[3:0] as captured in NEW_ROUND (checked against the bench's model).
2. Correct guess: drive `guess`=`target`, submit high for 10 cycles → exactly one `is_equal` cycle, 2 cycles after the internal press; `target` updates the following cycle; `tries_left`=3.
3. Bouncy submit: toggle `submit` every 2 cycles for 20 cycles, then hold high → exactly one judge, no extra pulses.
4. Three wrong guesses (`guess`=`target`^1): `is_wrong` pulses with `tries_left` 2→1→0; the third `is_wrong` coincides with `round_lost`; a new round starts and `tries_left`=3.
5. Change `guess` the cycle after the press: the result reflects the sampled value. A press during JUDGE (forced via debounce bypass) is ignored.
6. Assert `rst` in the cycle `is_equal` would fire → no pulse; state returns to NEW_ROUND and all outputs are at their reset values.
